nivel_display_mux: RTL and testbench
====================================

# nivel_display_mux

Parametrised successor to the three-sensor tank level display. Samples N level probes and debounces them. Validates that the probe pattern is a thermometer code and computes the level as a count. Drives a time-multiplexed 3-digit 7-segment display: two decimal level digits plus one status glyph. Adds a low-level alarm output and an optional blink on error. Sits between the raw tank probe pins and the board display/LED pins.

## Interface
Parameters:
- N_SENSORS, 3: number of level probes; legal range 2..16.
- DEBOUNCE_CYCLES, 4: consecutive differing cycles required to accept a probe change; ≥1.
- SCAN_DIV, 1000: clocks each digit stays enabled; ≥2.
- LOW_THRESH, 1: alarm_low asserted when level ≤ LOW_THRESH.
- BLINK_DIV, 25000000: blink half-period in clocks; used only with LEVEL_BLINK_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sensores  in  N_SENSORS  raw probe inputs, asynchronous to clk. Bit 0 is the lowest probe; 1 means wet.
- level  out  5  debounced water level, 0..N_SENSORS.
- err  out  1  debounced pattern is not a thermometer code.
- alarm_low  out  1  level ≤ LOW_THRESH and err=0.
- dig_n  out  3  digit enables, active-low, one-hot-low. Bit 0 is units, bit 1 is tens, bit 2 is status.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Input path: each probe bit passes a 2-flop synchroniser. This stage feeds a per-bit debounce counter sized for DEBOUNCE_CYCLES.
- Debounce rule:
  - When the synced bit ≠ the debounced bit, the counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES, the debounced bit flips and the counter clears.
  - When the synced bit = the debounced bit, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Validation:
  - The pattern is valid iff it equals 2^k−1 for some k in 0..N_SENSORS.
  - Valid pattern: level ← k, err ← 0.
  - Invalid pattern: err ← 1 and level holds its last valid value.
- alarm_low is registered with level and is forced to 0 while err=1.
- Display scanner:
  - A counter runs 0..SCAN_DIV−1; at wrap the digit index advances 0→1→2→0.
  - dig_n and seg_n are registered and updated together on the index change. Exactly one dig_n bit is low at any time after the first advance.
- Glyph per digit index:
  - Units digit: level mod 10. With err=1 it shows '-'.
  - Tens digit: level/10. It is blank when the tens value is 0. With err=1 it shows '-'.
  - Status digit: 'E' if err=1, else 'F' if level=N_SENSORS, else '-'.
- Segment codes (seg_n, hex, bit6=g):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Glyphs: E=06, F=0E, '-'=3F, blank=7F.

## Timing
- Reset values:
  - debounced pattern 0, all counters 0, digit index 0.
  - level=0, err=0, alarm_low=0.
  - dig_n=3'b111, seg_n=7'h7F.
- Reset is asynchronous. Deassertion mid-scan or mid-debounce restarts everything from the reset values.
- Latency from a sensores change held stable to the level/err/alarm_low update: 2 (sync) + DEBOUNCE_CYCLES + 1 (validate register) cycles.
- First display update: SCAN_DIV cycles after reset release, with dig_n=3'b101 (tens).
- Each digit is then lit for exactly SCAN_DIV cycles, giving a full frame of 3·SCAN_DIV cycles.
- A level change mid-frame appears at the next digit advance. The currently lit digit is not updated mid-slot.
- Simultaneous bit changes are debounced independently. A transient invalid pattern during a multi-bit change sets err for the cycles it is present.

## Configuration
- LEVEL_BLINK_EN defined:
  - A blink counter toggles a phase bit every BLINK_DIV cycles; the phase resets to "on".
  - While err=1 and the phase is "off", seg_n is forced to 7F; dig_n still scans.
  - Blink never applies when err=0.
- LEVEL_BLINK_EN undefined: no blink counter is present, and the error display is steady.

## Test plan
All scenarios use N_SENSORS=3, DEBOUNCE_CYCLES=4, SCAN_DIV=4, BLINK_DIV=8.
- Reset: hold rst_n=0 with sensores=3'b111. Required: level=0, err=0, dig_n=111, seg_n=7F. After release, level=3 at cycle 7; status digit seg_n=0E; units seg_n=30; tens seg_n=7F.
- Debounce: sensores 000→001 for 3 cycles, then back to 000. Required: level stays 0. Holding 001 for 4+ cycles gives level=1 and alarm_low=1.
- Error: sensores=3'b101 stable from level=1. Required: err=1 and level holds 1. Units and tens show 3F, status shows 06, alarm_low=0. Returning to 011 gives err=0 and level=2.
- Scan order: run 12 cycles. Required: dig_n sequence 101, 011, 110, each held for exactly 4 cycles, never two bits low.
- Blink (LEVEL_BLINK_EN): with err=1, seg_n=7F for 8 of every 16 cycles. With err=0, seg_n is never forced.
- Async reset mid-frame: pull rst_n low on a display cycle. Required: dig_n=111 and seg_n=7F in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/nivel_display_mux.sv
// nivel_display_mux: tank level probe front end and 3-digit multiplexed display.
// Probes are synchronised and debounced, then checked for a thermometer code
// to derive the water level. The level is shown as two decimal digits plus a
// status glyph on a time-multiplexed 7-segment display.
// Optional feature macro: LEVEL_BLINK_EN (blanks the segments at a slow rate while err=1).
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sensores   raw probe inputs, bit 0 = lowest probe, 1 = wet
//   level      debounced level 0..N_SENSORS
//   err        debounced probe pattern is not a thermometer code
//   alarm_low  level <= LOW_THRESH while err=0
//   dig_n      active-low digit enables {status, tens, units}
//   seg_n      active-low segments {g,f,e,d,c,b,a}
module nivel_display_mux #(
    parameter int unsigned N_SENSORS       = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned LOW_THRESH      = 1,
    parameter int unsigned BLINK_DIV       = 25000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] sensores,
    output logic [4:0]           level,
    output logic                 err,
    output logic                 alarm_low,
    output logic [2:0]           dig_n,
    output logic [6:0]           seg_n
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SC_W = $clog2(SCAN_DIV);
    localparam int unsigned PW   = N_SENSORS + 1;

    localparam logic [1:0] IDX_UNITS = 2'd0;
    localparam logic [1:0] IDX_TENS  = 2'd1;
    localparam logic [1:0] IDX_STAT  = 2'd2;

    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Elaboration-time parameter range check
    if (N_SENSORS < 2 || N_SENSORS > 16 || DEBOUNCE_CYCLES < 1 ||
        SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
        $error("nivel_display_mux: parameter out of range");
    end

    logic [N_SENSORS-1:0] sync1_q, sync2_q, deb_q, deb_d;
    logic [DB_W-1:0]      db_cnt_q [N_SENSORS];
    logic [DB_W-1:0]      db_cnt_d [N_SENSORS];
    logic [4:0]           level_q, level_d;
    logic                 err_q, err_d, alarm_q, alarm_d;
    logic [SC_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [1:0]           idx_q, idx_d, idx_nx;
    logic [2:0]           dig_q, dig_d;
    logic [6:0]           glyph_q, glyph_d, glyph_nx;
    logic                 scan_wrap;
    logic [PW-1:0]        pat_ext;
    logic                 pat_valid;
    logic [4:0]           ones;
    logic [3:0]           tens_val, units_val;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Thermometer check: p is 2^k-1 exactly when p & (p+1) == 0
    always_comb begin
        pat_ext   = {1'b0, deb_q};
        pat_valid = ((pat_ext + PW'(1)) & pat_ext) == '0;
        ones      = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            ones = ones + 5'(deb_q[i]);
        end
        level_d = pat_valid ? ones : level_q;
        err_d   = ~pat_valid;
        alarm_d = pat_valid && (32'(ones) <= LOW_THRESH);
    end

    // Digit index FSM: advances units -> tens -> status on each scan wrap
    always_comb begin
        scan_wrap  = (scan_cnt_q == SC_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SC_W'(1);
        case (idx_q)
            IDX_UNITS: idx_nx = IDX_TENS;
            IDX_TENS:  idx_nx = IDX_STAT;
            default:   idx_nx = IDX_UNITS;
        endcase
        idx_d = scan_wrap ? idx_nx : idx_q;
    end

    // Glyph for the digit about to be lit; level never exceeds 16 so tens is 0 or 1
    always_comb begin
        tens_val  = (level_q >= 5'd10) ? 4'd1 : 4'd0;
        units_val = 4'(level_q - ((level_q >= 5'd10) ? 5'd10 : 5'd0));
        case (idx_nx)
            IDX_UNITS: glyph_nx = err_q ? SEG_DASH : seg_of(units_val);
            IDX_TENS:  glyph_nx = err_q ? SEG_DASH :
                                  ((tens_val == 4'd0) ? SEG_BLANK : seg_of(tens_val));
            default:   glyph_nx = err_q ? SEG_E :
                                  ((level_q == 5'(N_SENSORS)) ? SEG_F : SEG_DASH);
        endcase
        dig_d   = dig_q;
        glyph_d = glyph_q;
        if (scan_wrap) begin
            glyph_d = glyph_nx;
            case (idx_nx)
                IDX_UNITS: dig_d = 3'b110;
                IDX_TENS:  dig_d = 3'b101;
                default:   dig_d = 3'b011;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < int'(N_SENSORS); i++) db_cnt_q[i] <= '0;
            level_q    <= '0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= IDX_UNITS;
            dig_q      <= 3'b111;
            glyph_q    <= SEG_BLANK;
        end else begin
            sync1_q    <= sensores;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < int'(N_SENSORS); i++) db_cnt_q[i] <= db_cnt_d[i];
            level_q    <= level_d;
            err_q      <= err_d;
            alarm_q    <= alarm_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            dig_q      <= dig_d;
            glyph_q    <= glyph_d;
        end
    end

`ifdef LEVEL_BLINK_EN
    localparam int unsigned BL_W = $clog2(BLINK_DIV + 1);

    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [6:0]      seg_q, seg_d;

    // Blink phase toggles every BLINK_DIV cycles; segments blanked in the off phase while err=1
    always_comb begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        seg_d = (err_q && !phase_d) ? SEG_BLANK : glyph_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            seg_q       <= SEG_BLANK;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
        end
    end

    assign seg_n = seg_q;
`else
    assign seg_n = glyph_q;
`endif

    assign level     = level_q;
    assign err       = err_q;
    assign alarm_low = alarm_q;
    assign dig_n     = dig_q;

endmodule

// File: tb/tb_nivel_display_mux.sv
// Self-checking bench for nivel_display_mux with N_SENSORS=3, DEBOUNCE_CYCLES=4,
// SCAN_DIV=4, BLINK_DIV=8. Level/err/alarm vectors go through a scoreboard queue.
module tb_nivel_display_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sensores = 3'b111;
    logic [4:0] level;
    logic       err, alarm_low;
    logic [2:0] dig_n;
    logic [6:0] seg_n;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [2:0] pat;
        int         hold;
        logic [4:0] lvl;
        logic       err;
        logic       alm;
    } vec_t;

    typedef struct {
        logic [4:0] lvl;
        logic       err;
        logic       alm;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    nivel_display_mux #(
        .N_SENSORS(3), .DEBOUNCE_CYCLES(4), .SCAN_DIV(4),
        .LOW_THRESH(1), .BLINK_DIV(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensores(sensores),
        .level(level), .err(err), .alarm_low(alarm_low),
        .dig_n(dig_n), .seg_n(seg_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Wait out the current slot, then watch one full frame and check each digit's glyph
    task automatic check_frame(input logic [6:0] u, input logic [6:0] t, input logic [6:0] s);
        logic [2:0] seen;
        seen = 3'b000;
        step(4);
        for (int c = 0; c < 12; c++) begin
            step(1);
            case (dig_n)
                3'b110: begin chk("frame_units", 32'(seg_n), 32'(u)); seen[0] = 1'b1; end
                3'b101: begin chk("frame_tens",  32'(seg_n), 32'(t)); seen[1] = 1'b1; end
                3'b011: begin chk("frame_stat",  32'(seg_n), 32'(s)); seen[2] = 1'b1; end
                default: chk("frame_dig", 32'(dig_n), 32'h7);
            endcase
        end
        chk("frame_seen", 32'(seen), 32'h7);
    endtask

    initial begin
        exp_t       e;
        logic [2:0] exp_dig;
        logic [6:0] exp_seg;
        int         n7f;

        vecs[0]  = '{3'b000, 10, 5'd0, 1'b0, 1'b1};
        vecs[1]  = '{3'b001,  3, 5'd0, 1'b0, 1'b1};  // 3-cycle glitch
        vecs[2]  = '{3'b000,  4, 5'd0, 1'b0, 1'b1};
        vecs[3]  = '{3'b000,  6, 5'd0, 1'b0, 1'b1};
        vecs[4]  = '{3'b001, 10, 5'd1, 1'b0, 1'b1};
        vecs[5]  = '{3'b101, 10, 5'd1, 1'b1, 1'b0};
        vecs[6]  = '{3'b011, 10, 5'd2, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 10, 5'd3, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 10, 5'd3, 1'b1, 1'b0};
        vecs[9]  = '{3'b000, 10, 5'd0, 1'b0, 1'b1};
        vecs[10] = '{3'b010, 10, 5'd0, 1'b1, 1'b0};
        vecs[11] = '{3'b001, 10, 5'd1, 1'b0, 1'b1};

        // Reset values while rst_n is held low with all probes wet
        step(2);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_alarm", 32'(alarm_low), 32'd0);
        chk("rst_dig",   32'(dig_n), 32'h7);
        chk("rst_seg",   32'(seg_n), 32'h7F);

        // Release: latency to level=3 and first frame of the scanner
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step(1);
            if (c < 4) begin
                exp_dig = 3'b111; exp_seg = 7'h7F;
            end else begin
                case (((c - 4) / 4) % 3)
                    0:       begin exp_dig = 3'b101; exp_seg = 7'h7F; end
                    1:       begin exp_dig = 3'b011; exp_seg = 7'h0E; end
                    default: begin exp_dig = 3'b110; exp_seg = 7'h30; end
                endcase
            end
            chk($sformatf("start_dig_c%0d", c),   32'(dig_n), 32'(exp_dig));
            chk($sformatf("start_seg_c%0d", c),   32'(seg_n), 32'(exp_seg));
            chk($sformatf("start_level_c%0d", c), 32'(level), (c >= 7) ? 32'd3 : 32'd0);
            chk($sformatf("start_alarm_c%0d", c), 32'(alarm_low), (c >= 7) ? 32'd0 : 32'd1);
        end

        // Table-driven level/err/alarm vectors through the scoreboard
        for (int i = 0; i < 12; i++) begin
            sensores = vecs[i].pat;
            sb.push_back('{vecs[i].lvl, vecs[i].err, vecs[i].alm});
            step(vecs[i].hold);
            e = sb.pop_front();
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(e.lvl));
            chk($sformatf("vec%0d_err", i),   32'(err), 32'(e.err));
            chk($sformatf("vec%0d_alarm", i), 32'(alarm_low), 32'(e.alm));
        end

        // Error display from level=1
        sensores = 3'b101;
        step(10);
        chk("errdisp_level", 32'(level), 32'd1);
        chk("errdisp_err",   32'(err), 32'd1);
        check_frame(7'h3F, 7'h3F, 7'h06);

`ifdef LEVEL_BLINK_EN
        n7f = 0;
        for (int c = 0; c < 16; c++) begin
            step(1);
            if (seg_n == 7'h7F) n7f++;
        end
        chk("blink_off_cycles", 32'(n7f), 32'd8);
`else
        n7f = 0;
`endif

        // Back to a valid pattern: level 2
        sensores = 3'b011;
        step(10);
        chk("recover_level", 32'(level), 32'd2);
        chk("recover_err",   32'(err), 32'd0);
        check_frame(7'h24, 7'h7F, 7'h3F);

`ifdef LEVEL_BLINK_EN
        n7f = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (seg_n == 7'h7F) n7f++;
        end
        chk("blink_noerr_7f", 32'(n7f), 32'd4);
`endif

        // Exact latency of a simultaneous two-bit change 011 -> 000
        sensores = 3'b000;
        step(6);
        chk("lat_before_level", 32'(level), 32'd2);
        step(1);
        chk("lat_after_level", 32'(level), 32'd0);
        chk("lat_after_alarm", 32'(alarm_low), 32'd1);

        // Asynchronous reset mid-frame, checked before any clock edge
        step(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dig",   32'(dig_n), 32'h7);
        chk("arst_seg",   32'(seg_n), 32'h7F);
        chk("arst_alarm", 32'(alarm_low), 32'd0);
        #3;
        rst_n = 1'b1;
        step(2);
        chk("arst_restart_dig2", 32'(dig_n), 32'h7);
        step(2);
        chk("arst_restart_dig4", 32'(dig_n), 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
